// File: rtl/alu_pkg.sv
// alu_pkg: shared defaults and types for the EX-stage ALU result skid stage.
//   ALU_WIDTH / ALU_RD_W : default datapath and destination-index widths
//   alu_flags_t          : packed {zero, neg, carry, ovf} flag bundle
//   skid_state_t         : skid occupancy; bit 0 = main valid, bit 1 = skid valid
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 64;
   localparam int unsigned ALU_RD_W  = 5;

   typedef struct packed {
      logic zero;
      logic neg;
      logic carry;
      logic ovf;
   } alu_flags_t;

   // Encoding chosen so the valid bits are the state flops themselves.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } skid_state_t;

endpackage

// File: rtl/alu_result_skid_if.sv
// alu_result_skid_if: upstream (adder/subtractor) and downstream (EX/MEM) handshake bundle.
//   master : environment side; drives in_* payload, in_valid and out_ready
//   slave  : skid stage side; drives in_ready, out_valid and registered out_* payload
interface alu_result_skid_if
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH,
   parameter int unsigned RD_W  = ALU_RD_W
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_diff;
   logic             in_cout;
   logic             in_a_msb;
   logic             in_b_msb;
   logic             in_sub;
   logic [RD_W-1:0]  in_rd;
   logic             in_wb_en;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic [RD_W-1:0]  out_rd;
   logic             out_wb_en;
   logic             out_zero;
   logic             out_neg;
   logic             out_carry;
   logic             out_ovf;

   modport master (
      output in_valid, in_diff, in_cout, in_a_msb, in_b_msb, in_sub, in_rd, in_wb_en,
      output out_ready,
      input  in_ready,
      input  out_valid, out_result, out_rd, out_wb_en, out_zero, out_neg, out_carry, out_ovf
   );

   modport slave (
      input  in_valid, in_diff, in_cout, in_a_msb, in_b_msb, in_sub, in_rd, in_wb_en,
      input  out_ready,
      output in_ready,
      output out_valid, out_result, out_rd, out_wb_en, out_zero, out_neg, out_carry, out_ovf
   );

endinterface

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: combinational zero/negative/carry/overflow derivation from the raw
// adder/subtractor result.
//   diff_i    : Diff/Sum
//   cout_i    : raw carry-out (for subtract, 1 = no borrow)
//   a_msb_i   : operand A sign bit
//   b_msb_i   : operand B sign bit before inversion
//   sub_i     : 1 = subtract, 0 = add
//   flags_o_c : combinational flag bundle
module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] diff_i,
   input  logic             cout_i,
   input  logic             a_msb_i,
   input  logic             b_msb_i,
   input  logic             sub_i,
   output alu_flags_t       flags_o_c
);

   // Effective B sign as seen by the adder; subtract feeds ~B.
   logic b_eff_c;
   assign b_eff_c = b_msb_i ^ sub_i;

   always_comb begin
      flags_o_c       = '0;
      flags_o_c.zero  = (diff_i == '0);
      flags_o_c.neg   = diff_i[WIDTH-1];
      flags_o_c.carry = cout_i;
      flags_o_c.ovf   = (a_msb_i == b_eff_c) && (diff_i[WIDTH-1] != a_msb_i);
   end

endmodule

// File: rtl/alu_result_skid.sv
// alu_result_skid: registered two-entry valid/ready skid stage between the EX-stage
// 64-bit adder/subtractor and EX/MEM. Breaks the carry-chain path into MEM logic and
// lets MEM stall without losing an in-flight result.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   flush : synchronous flush; drops both entries and any same-cycle input
//   bus   : slave side of alu_result_skid_if (in_* upstream, out_* downstream)
// Build option: define ALU_FLAGS_EN to compute and store flags; otherwise the flag
// outputs are tied low and in_a_msb/in_b_msb/in_sub/in_cout are ignored.
module alu_result_skid
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH,
   parameter int unsigned RD_W  = ALU_RD_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   alu_result_skid_if.slave   bus
);

   skid_state_t state_q, state_d;
   logic        main_valid;
   logic        skid_valid;
   logic        accept_c;
   logic        release_c;
   logic        load_main_in_c;
   logic        load_main_skid_c;
   logic        load_skid_c;

   logic [WIDTH-1:0] main_result_q, main_result_d;
   logic [RD_W-1:0]  main_rd_q, main_rd_d;
   logic             main_wb_q, main_wb_d;
   logic [WIDTH-1:0] skid_result_q, skid_result_d;
   logic [RD_W-1:0]  skid_rd_q, skid_rd_d;
   logic             skid_wb_q, skid_wb_d;

   assign main_valid = state_q[0];
   assign skid_valid = state_q[1];
   assign accept_c   = bus.in_valid && !skid_valid;
   assign release_c  = main_valid && bus.out_ready;

   // Occupancy control and entry load selects.
   always_comb begin
      state_d          = state_q;
      load_main_in_c   = 1'b0;
      load_main_skid_c = 1'b0;
      load_skid_c      = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept_c) begin
                  state_d        = ONE;
                  load_main_in_c = 1'b1;
               end
            end
            ONE: begin
               if (accept_c && !release_c) begin
                  state_d     = FULL;
                  load_skid_c = 1'b1;
               end else if (accept_c && release_c) begin
                  load_main_in_c = 1'b1;
               end else if (release_c) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (release_c) begin
                  state_d          = ONE;
                  load_main_skid_c = 1'b1;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Payload next-state; flush leaves payload untouched.
   always_comb begin
      main_result_d = main_result_q;
      main_rd_d     = main_rd_q;
      main_wb_d     = main_wb_q;
      skid_result_d = skid_result_q;
      skid_rd_d     = skid_rd_q;
      skid_wb_d     = skid_wb_q;
      if (load_main_in_c) begin
         main_result_d = bus.in_diff;
         main_rd_d     = bus.in_rd;
         main_wb_d     = bus.in_wb_en;
      end else if (load_main_skid_c) begin
         main_result_d = skid_result_q;
         main_rd_d     = skid_rd_q;
         main_wb_d     = skid_wb_q;
      end
      if (load_skid_c) begin
         skid_result_d = bus.in_diff;
         skid_rd_d     = bus.in_rd;
         skid_wb_d     = bus.in_wb_en;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= EMPTY;
         main_result_q <= '0;
         main_rd_q     <= '0;
         main_wb_q     <= 1'b0;
         skid_result_q <= '0;
         skid_rd_q     <= '0;
         skid_wb_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         main_result_q <= main_result_d;
         main_rd_q     <= main_rd_d;
         main_wb_q     <= main_wb_d;
         skid_result_q <= skid_result_d;
         skid_rd_q     <= skid_rd_d;
         skid_wb_q     <= skid_wb_d;
      end
   end

   assign bus.in_ready   = !skid_valid;
   assign bus.out_valid  = main_valid;
   assign bus.out_result = main_result_q;
   assign bus.out_rd     = main_rd_q;
   assign bus.out_wb_en  = main_wb_q;

`ifdef ALU_FLAGS_EN
   alu_flags_t in_flags_c;
   alu_flags_t main_flags_q, main_flags_d;
   alu_flags_t skid_flags_q, skid_flags_d;

   alu_flag_gen #(
      .WIDTH (WIDTH)
   ) u_flag_gen (
      .diff_i    (bus.in_diff),
      .cout_i    (bus.in_cout),
      .a_msb_i   (bus.in_a_msb),
      .b_msb_i   (bus.in_b_msb),
      .sub_i     (bus.in_sub),
      .flags_o_c (in_flags_c)
   );

   // Flags follow their payload through the same load selects.
   always_comb begin
      main_flags_d = main_flags_q;
      skid_flags_d = skid_flags_q;
      if (load_main_in_c) begin
         main_flags_d = in_flags_c;
      end else if (load_main_skid_c) begin
         main_flags_d = skid_flags_q;
      end
      if (load_skid_c) begin
         skid_flags_d = in_flags_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_flags_q <= '0;
         skid_flags_q <= '0;
      end else begin
         main_flags_q <= main_flags_d;
         skid_flags_q <= skid_flags_d;
      end
   end

   assign bus.out_zero  = main_flags_q.zero;
   assign bus.out_neg   = main_flags_q.neg;
   assign bus.out_carry = main_flags_q.carry;
   assign bus.out_ovf   = main_flags_q.ovf;
`else
   assign bus.out_zero  = 1'b0;
   assign bus.out_neg   = 1'b0;
   assign bus.out_carry = 1'b0;
   assign bus.out_ovf   = 1'b0;
`endif

endmodule
